// File: rtl/iterative_mul_div_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2^MUL_STEP shift-add multiplier,
// restoring divider on magnitudes, one-cycle divide corner cases, tagged valid/ready response.
module iterative_mul_div_unit #(
    parameter int XLEN      = 32,
    parameter int MUL_STEP  = 4,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_code,
    input  logic [XLEN-1:0]      req_op1,
    input  logic [XLEN-1:0]      req_op2,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic [TAG_WIDTH-1:0] resp_tag
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    localparam logic [CW-1:0] MUL_ITERS = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0] DIV_ITERS = CW'(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;     // mul: running product; div: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   b_mag;   // mul: multiplier shifted right; div: divisor
    logic              neg_q, neg_r, is_rem, mul_hi;

    // accept-time decode
    logic              is_mul, s1, s2, neg1, neg2;
    logic [XLEN-1:0]   op1_mag, op2_mag;
    // iteration datapath
    logic [2*XLEN-1:0] part, acc_mul, mul_fix;
    logic [XLEN-1:0]   mul_res, rem_nx, quo_nx, div_res;
    logic [XLEN:0]     r_sh, diff;
    logic              ge;

    assign req_ready  = (state == S_IDLE) && !clear;
    assign resp_valid = (state == S_DONE);

    always_comb begin
        is_mul  = !req_code[2];
        s1      = is_mul ? (req_code != 3'd3) : !req_code[0];
        s2      = is_mul ? !req_code[1] : !req_code[0];
        neg1    = s1 && req_op1[XLEN-1];
        neg2    = s2 && req_op2[XLEN-1];
        op1_mag = neg1 ? -req_op1 : req_op1;
        op2_mag = neg2 ? -req_op2 : req_op2;

        part    = mcand * {{(2*XLEN-MUL_STEP){1'b0}}, b_mag[MUL_STEP-1:0]};
        acc_mul = acc + part;
        mul_fix = neg_q ? -acc_mul : acc_mul;
        mul_res = mul_hi ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];

        r_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = r_sh - {1'b0, b_mag};
        ge      = !diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        quo_nx  = {acc[XLEN-2:0], ge};
        div_res = is_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            b_mag     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is_rem    <= 1'b0;
            mul_hi    <= 1'b0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    resp_tag <= req_tag;
                    mcand    <= {{XLEN{1'b0}}, op1_mag};
                    b_mag    <= op2_mag;
                    acc      <= is_mul ? '0 : {{XLEN{1'b0}}, op1_mag};
                    neg_q    <= neg1 ^ neg2;
                    neg_r    <= neg1;
                    is_rem   <= req_code[1];
                    mul_hi   <= (req_code[1:0] != 2'd0);
                    if (is_mul) begin
                        cnt   <= MUL_ITERS;
                        state <= S_MUL;
                    end else if (req_op2 == '0) begin
                        resp_data <= req_code[1] ? req_op1 : '1;
                        state     <= S_DONE;
                    end else if (!req_code[0] && req_op1 == SMIN && req_op2 == '1) begin
                        // signed overflow: quotient wraps to op1, remainder is zero
                        resp_data <= req_code[1] ? '0 : req_op1;
                        state     <= S_DONE;
                    end else begin
                        cnt   <= DIV_ITERS;
                        state <= S_DIV;
                    end
                end
                S_MUL: begin
                    acc   <= acc_mul;
                    mcand <= mcand << MUL_STEP;
                    b_mag <= b_mag >> MUL_STEP;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        resp_data <= mul_res;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc <= {rem_nx, quo_nx};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        resp_data <= div_res;
                        state     <= S_DONE;
                    end
                end
                default: if (resp_ready) state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_mul_div_unit.sv
// Scoreboard bench for iterative_mul_div_unit (XLEN=32, MUL_STEP=4): random and directed
// RV32M operations checked against an arithmetic reference model, plus clear/reset/back-pressure.
module tb_iterative_mul_div_unit;
    localparam logic [31:0] SMIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_code = 3'd0;
    logic [31:0] req_op1 = '0, req_op2 = '0;
    logic [4:0]  req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;

    iterative_mul_div_unit #(.XLEN(32), .MUL_STEP(4), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
        .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   nchk = 0, nfail = 0, cyc = 0;
    logic hold = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (c)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return a;
                r = sa / sb; return r[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
                r = sa % sb; return r[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c < 3'd4) return 32 / 4 + 1;
        if (b == 0 || (!c[0] && a == SMIN && b == 32'hFFFF_FFFF)) return 1;
        return 32 + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return SMIN;
            4: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    // Drive one request, push its expectation when acceptance is certain, then scramble inputs.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_code = c; req_op1 = a; req_op2 = b; req_tag = t;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (ok) q.push_back('{ref_res(c, a, b), t, cyc, ref_lat(c, a, b)});
        else chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_code = 3'($urandom); req_op1 = $urandom; req_op2 = $urandom; req_tag = 5'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        resp_ready = hold ? 1'b0 : ($urandom % 3 != 0);
    end

    // monitor: every cycle the response is shown it must match the queue head and block new requests
    initial forever begin
        @(negedge clk);
        if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                chk("resp_data", 64'(resp_data), 64'(q[0].d));
                chk("resp_tag", 64'(resp_tag), 64'(q[0].t));
                chk("req_ready_in_done", 64'(req_ready), 64'd0);
                if (!prev_valid) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                if (resp_ready) void'(q.pop_front());
            end
        end
        prev_valid = resp_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_tag", 64'(resp_tag), 64'd0);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        issue(3'd1, SMIN, SMIN, 5'd4);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        issue(3'd5, 32'd100, 32'd7, 5'd6);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
        issue(3'd4, SMIN, 32'hFFFF_FFFF, 5'd8);
        issue(3'd4, 32'd5, 32'd0, 5'd9);
        issue(3'd7, 32'd5, 32'd0, 5'd10);
        issue(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd11);
        drain();

        // back-pressure: response must stay put while the consumer stalls
        hold = 1'b1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21);
        for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("bp_valid_held", 64'(resp_valid), 64'd1);
        chk("bp_queue_kept", 64'(q.size()), 64'd1);
        hold = 1'b0;
        drain();

        // clear mid-divide, with a request offered in the clear cycle
        issue(3'd5, 32'd1000, 32'd3, 5'd12);
        repeat (9) @(posedge clk);
        #1 clear = 1'b1; q.delete();
        req_valid = 1'b1; req_code = 3'd0; req_op1 = 32'd3; req_op2 = 32'd3; req_tag = 5'd13;
        @(negedge clk);
        chk("clear_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 clear = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_clear_ready", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (resp_valid) seen++; end
        chk("clear_no_resp", 64'(seen), 64'd0);

        // reset mid-multiply loses the result and restores reset values
        issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; q.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(resp_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_data", 64'(resp_data), 64'd0);
        chk("midrst_tag", 64'(resp_tag), 64'd0);

        for (int n = 0; n < 150; n++) issue(3'($urandom), pick(), pick(), 5'($urandom));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
